// File: rtl/fifo_read_checker.sv
// fifo_read_checker: burst-drains an external FIFO and checks a wrapping incrementing pattern.
// Define FIFO_CHECK_RESYNC_EN to resync the expected value to the received data after a mismatch.
module fifo_read_checker #(
    parameter int DW         = 8,
    parameter int RD_LAT     = 1,
    parameter int PAT_START  = 0,
    parameter int PAT_STOP   = 255,
    parameter int BLOCK_LEN  = 102400,
    parameter int CNT_W      = 24,
    parameter int START_MODE = 0,
    parameter int RST_CYC    = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          en,
    output logic          fifo_re,
    output logic          fifo_rrst,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          err_flag,
    output logic [15:0]   err_cnt,
    output logic [3:0]    blk_cnt,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, RST, WAIT, READ} state_t;
    localparam int RW = $clog2(RST_CYC + 1);
    localparam logic [DW-1:0] P_START = DW'(PAT_START);
    localparam logic [DW-1:0] P_STOP = DW'(PAT_STOP);
    state_t state, state_nxt;
    logic [RW-1:0] rst_cnt;
    logic [RD_LAT-1:0] re_pipe;
    logic [DW-1:0] exp_val;
    logic [CNT_W-1:0] wcnt;
    logic blk_err, mis, blk_end, start;
    function automatic logic [DW-1:0] pat_next(input logic [DW-1:0] v);
        return (v == P_STOP) ? P_START : v + 1'b1;
    endfunction
    // full together with empty counts as empty, so a burst never opens on an empty FIFO
    always_comb begin
        start     = (START_MODE != 0) ? !fifo_empty : (fifo_full && !fifo_empty);
        state_nxt = !en ? IDLE :
                    (state == IDLE) ? RST :
                    (state == RST && rst_cnt == RW'(RST_CYC - 1)) ? WAIT :
                    (state == WAIT && start) ? READ :
                    (state == READ && fifo_empty) ? WAIT : state;
        fifo_re   = en && state == READ && !fifo_empty;
        fifo_rrst = state == IDLE || state == RST;
        busy      = state != IDLE;
        mis       = rd_valid && rd_data != exp_val;
        blk_end   = rd_valid && wcnt == CNT_W'(BLOCK_LEN - 1);
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            rst_cnt  <= '0;
            re_pipe  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            rst_cnt  <= (state == RST) ? rst_cnt + 1'b1 : '0;
            re_pipe  <= (re_pipe << 1) | RD_LAT'(fifo_re);
            rd_valid <= re_pipe[RD_LAT-1];
            if (re_pipe[RD_LAT-1])
                rd_data <= fifo_dout;
        end
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            exp_val  <= P_START;
            wcnt     <= '0;
            blk_err  <= 1'b0;
            blk_cnt  <= '0;
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (rd_valid) begin
`ifdef FIFO_CHECK_RESYNC_EN
                exp_val <= pat_next(rd_data);
`else
                exp_val <= pat_next(exp_val);
`endif
                wcnt    <= blk_end ? '0 : wcnt + 1'b1;
                blk_err <= !blk_end && (blk_err || mis);
                if (blk_end && !blk_err && !mis)
                    blk_cnt <= blk_cnt + 1'b1;
            end
            if (mis) begin
                err_flag <= 1'b1;
                if (err_cnt != 16'hFFFF)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_read_checker.sv
// tb_fifo_read_checker: directed bench for fifo_read_checker with a registered-output FIFO model.
module tb_fifo_read_checker;
    logic clk = 0, n_rst = 0, en = 0, full_force = 0;
    logic [7:0] fifo_dout = '0;
    logic fifo_re, fifo_rrst, fifo_full, fifo_empty, rd_valid, err_flag, busy;
    logic [7:0] rd_data;
    logic [15:0] err_cnt;
    logic [3:0] blk_cnt;
    logic [7:0] mem [0:1023];
    int wp = 0, rp = 0;
    int checks = 0, errors = 0;

    fifo_read_checker #(.BLOCK_LEN(16)) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .fifo_re(fifo_re), .fifo_rrst(fifo_rrst),
        .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .rd_data(rd_data), .rd_valid(rd_valid), .err_flag(err_flag), .err_cnt(err_cnt),
        .blk_cnt(blk_cnt), .busy(busy)
    );

    always #5 clk = ~clk;
    assign fifo_empty = (wp == rp);
    assign fifo_full = full_force || (wp - rp >= 256);

    always @(posedge clk) begin
        if (fifo_rrst)
            rp <= wp;
        else if (fifo_re) begin
            fifo_dout <= mem[rp % 1024];
            rp <= rp + 1;
        end
    end

    task do_reset;
        n_rst = 0; en = 0; full_force = 0;
        repeat (2) @(negedge clk);
        n_rst = 1;
        @(negedge clk);
    endtask

    task start_run;
        en = 1;
        repeat (6) @(negedge clk);
    endtask

    task push(input logic [7:0] v);
        mem[wp % 1024] = v;
        wp = wp + 1;
    endtask

    task kick;
        full_force = 1;
        @(negedge clk);
        full_force = 0;
    endtask

    task drain(input int n, output int got, output int lat, output int bad);
        int re_t, v_t;
        got = 0; re_t = -1; v_t = -1; bad = 0;
        for (int k = 0; k < 3000 && got < n; k++) begin
            @(negedge clk);
            if (fifo_re && re_t < 0) re_t = k;
            if (rd_valid) begin
                if (v_t < 0) v_t = k;
                got++;
            end
            if (fifo_re && fifo_empty) bad++;
        end
        lat = v_t - re_t;
        repeat (2) @(negedge clk);
    endtask

    task test_reset;
        n_rst = 0; en = 0;
        @(negedge clk);
        checks++; if (fifo_rrst !== 1'b1) begin errors++; $display("FAIL reset_rrst: got %b expected 1", fifo_rrst); end
        checks++; if (fifo_re !== 1'b0) begin errors++; $display("FAIL reset_re: got %b expected 0", fifo_re); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_err_flag: got %b expected 0", err_flag); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (blk_cnt !== 4'd0) begin errors++; $display("FAIL reset_blk_cnt: got %0d expected 0", blk_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_rst = 1;
        @(negedge clk);
    endtask

    task test_enable;
        int n;
        n = 0;
        en = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fifo_rrst) n++; else break;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL enable_rrst_cycles: got %0d expected 4", n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enable_busy: got %b expected 1", busy); end
        repeat (5) @(negedge clk);
        checks++; if (fifo_re !== 1'b0) begin errors++; $display("FAIL enable_wait_re: got %b expected 0", fifo_re); end
    endtask

    task test_burst;
        int got, lat, bad;
        do_reset; start_run;
        for (int i = 0; i < 256; i++) push(8'(i));
        drain(256, got, lat, bad);
        checks++; if (got !== 256) begin errors++; $display("FAIL burst_count: got %0d expected 256", got); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL burst_latency: got %0d expected 2", lat); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL burst_empty_read: got %0d expected 0", bad); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL burst_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (blk_cnt !== 4'd0) begin errors++; $display("FAIL burst_blk_wrap: got %0d expected 0", blk_cnt); end
        checks++; if (rd_data !== 8'd255) begin errors++; $display("FAIL burst_last_data: got %0d expected 255", rd_data); end
        checks++; if (fifo_re !== 1'b0) begin errors++; $display("FAIL burst_re_after: got %b expected 0", fifo_re); end
    endtask

    task test_wrap;
        int got, lat, bad;
        do_reset; start_run;
        for (int i = 0; i < 254; i++) push(8'(i));
        kick;
        drain(254, got, lat, bad);
        push(8'd254); push(8'd255); push(8'd0); push(8'd1);
        kick;
        drain(4, got, lat, bad);
        checks++; if (got !== 4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", got); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL wrap_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL wrap_err_flag: got %b expected 0", err_flag); end
    endtask

    task test_resync;
        int got, lat, bad, exp_err;
`ifdef FIFO_CHECK_RESYNC_EN
        exp_err = 1;
`else
        exp_err = 2;
`endif
        do_reset; start_run;
        push(8'd0); push(8'd1); push(8'd2); push(8'd4); push(8'd5);
        kick;
        drain(5, got, lat, bad);
        checks++; if (int'(err_cnt) !== exp_err) begin errors++; $display("FAIL resync_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
        checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL resync_err_flag: got %b expected 1", err_flag); end
    endtask

    task test_blocks;
        int got, lat, bad;
        do_reset; start_run;
        for (int i = 0; i < 48; i++) push(8'(i));
        kick;
        drain(48, got, lat, bad);
        checks++; if (blk_cnt !== 4'd3) begin errors++; $display("FAIL blocks_clean: got %0d expected 3", blk_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL blocks_clean_err: got %0d expected 0", err_cnt); end
        do_reset; start_run;
        for (int i = 0; i < 31; i++) push(8'(i));
        push(8'd99);
`ifdef FIFO_CHECK_RESYNC_EN
        for (int i = 100; i < 116; i++) push(8'(i));
`else
        for (int i = 32; i < 48; i++) push(8'(i));
`endif
        kick;
        drain(48, got, lat, bad);
        checks++; if (blk_cnt !== 4'd2) begin errors++; $display("FAIL blocks_bad: got %0d expected 2", blk_cnt); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL blocks_bad_err: got %0d expected 1", err_cnt); end
    endtask

    task test_midreset;
        do_reset; start_run;
        for (int i = 0; i < 200; i++) push(8'd7);
        kick;
        repeat (30) @(negedge clk);
        checks++; if (err_cnt === 16'd0) begin errors++; $display("FAIL mid_pre_err: got %0d expected nonzero", err_cnt); end
        checks++; if (fifo_re !== 1'b1) begin errors++; $display("FAIL mid_pre_re: got %b expected 1", fifo_re); end
        #2 n_rst = 0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", rd_valid); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL mid_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (blk_cnt !== 4'd0) begin errors++; $display("FAIL mid_blk_cnt: got %0d expected 0", blk_cnt); end
        checks++; if (fifo_re !== 1'b0) begin errors++; $display("FAIL mid_re: got %b expected 0", fifo_re); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (fifo_rrst !== 1'b1) begin errors++; $display("FAIL mid_rrst: got %b expected 1", fifo_rrst); end
        en = 0;
        @(negedge clk);
        n_rst = 1;
    endtask

    initial begin
        test_reset;
        test_enable;
        test_burst;
        test_wrap;
        test_resync;
        test_blocks;
        test_midreset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_read_checker.md
Name: fifo_read_checker

Overview:
- Parametrised read-side controller and pattern checker for an external FIFO.
- Drains the FIFO in bursts and re-times data into a valid-qualified stream.
- Checks the data against a wrapping incrementing pattern, counts errors, and advances an LED block counter per error-free block.
- Single clock domain, replacing the dual-phase read scheme.

Parameters:
- DW, 8, data width.
- RD_LAT, 1, cycles from fifo_re high to the word on fifo_dout (1..4).
- PAT_START, 0, first pattern value.
- PAT_STOP, 255, last pattern value before wrap; PAT_STOP > PAT_START.
- BLOCK_LEN, 102400, words per LED block.
- CNT_W, 24, width of the block word counter; 2^CNT_W > BLOCK_LEN.
- START_MODE, 0: a burst starts on fifo_full; 1: a burst starts on !fifo_empty.
- RST_CYC, 4, cycles fifo_rrst is held after enable.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- fifo_re  out  1  FIFO read enable.
- fifo_rrst  out  1  FIFO read-side reset, active high.
- fifo_dout  in  DW  FIFO read data.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- rd_data  out  DW  registered read data.
- rd_valid  out  1  rd_data qualifier, one word per high cycle.
- err_flag  out  1  sticky mismatch flag.
- err_cnt  out  16  saturating mismatch count.
- blk_cnt  out  4  error-free block count (LEDs), wraps 15->0.
- busy  out  1  high in RST, WAIT or READ.

Behaviour:
- Reset: all outputs 0, except fifo_rrst=1. State=IDLE. Expected value=PAT_START. Word counter=0. Block-error bit=0. Latency pipe cleared.
- IDLE: fifo_rrst=1. When en=1, go to RST.
- RST: fifo_rrst=1 for RST_CYC cycles, then 0. Go to WAIT.
- WAIT: go to READ when fifo_full=1 (START_MODE=0) or fifo_empty=0 (START_MODE=1).
- READ: fifo_re = (state==READ) & !fifo_empty, combinational, so the FIFO is never read while empty. Return to WAIT on the first cycle fifo_empty=1.
- en=0 in any state: go to IDLE next cycle; fifo_re drops in that same cycle. Words already in the pipe still emerge. Counters and errors are held, not cleared.
- Latency pipe: RD_LAT-deep shift of fifo_re. When the tap is high, rd_data<=fifo_dout and rd_valid=1 on the next cycle. Total latency fifo_re -> rd_valid is RD_LAT+1 cycles.
- Checker, on each rd_valid word:
  - Compare rd_data against the expected value.
  - Match: expected <= expected==PAT_STOP ? PAT_START : expected+1.
  - Mismatch: err_flag<=1 (sticky until reset), err_cnt+1 saturating at 0xFFFF, block-error bit set; expected handling per Optional Feature.
  - Compare is unsigned over the full DW.
- Block counter: increments per valid word. On the word that makes it BLOCK_LEN it reloads to 0. That same cycle, blk_cnt increments only if the block-error bit is clear (including this word's compare); the block-error bit is then cleared.
- Simultaneous flag events: fifo_full and fifo_empty both high is treated as empty, so no read occurs. Mid-burst flag glitches cannot cause an empty read because of the combinational gating.
- Reset mid-burst: everything returns to reset values immediately; in-flight words are dropped.

Optional Feature:
- Macro FIFO_CHECK_RESYNC_EN.
- Defined: on a mismatch, expected <= next pattern value after the received data, so one dropped word costs one error.
- Undefined: expected advances as if the word matched, so an offset stream counts an error on every word.

Test Plan:
- Reset release, en=1: fifo_rrst high 4 cycles then low, busy=1, fifo_re=0 until fifo_full (START_MODE=0).
- FIFO preloaded with 0..255, RD_LAT=1, START_MODE=0: 256 valid words, first rd_valid 2 cycles after fifo_re, err_cnt=0, fifo_re low the cycle empty rises.
- Stream 254,255,0,1 with PAT_STOP=255: no errors; wrap accepted.
- Stream 0,1,2,4,5 with resync on: err_cnt=1, err_flag=1. Same stream with resync off: err_cnt=2.
- BLOCK_LEN=16 with 48 correct words: blk_cnt=3. Same run with one bad word in the second block: blk_cnt=2.
- n_rst pulsed low mid-burst: rd_valid=0, err_cnt=0, blk_cnt=0, fifo_re=0 asynchronously; state returns to IDLE.
